uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_tx_queue.sv | 109 ++++++++++
 tb/tb_uart_tx_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit queue: feeder FSM states and the default byte width.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; occupancy is the difference of the registered pointers.
import uart_pkg::*;

module sync_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_wr_fire;
  logic                  w_rd_fire;

  // full/empty come from registered pointers only, so a same-cycle pop never admits a write when full
  assign count     = r_wr_ptr - r_rd_ptr;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign w_wr_fire = wr_en && !full;
  assign w_rd_fire = rd_en && !empty;
  assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a uart transmitter through a start-pulse / busy handshake.
// Optional feature macro: UART_TXQ_DROP_CNT_EN adds the saturating drop_cnt output.
import uart_pkg::*;

module uart_tx_queue #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [DATA_WIDTH-1:0]    data_in,
  output logic                     data_en,
  input  logic                     tx_busy,
`ifdef UART_TXQ_DROP_CNT_EN
  output logic [7:0]               drop_cnt,
`endif
  output feeder_state_e            dbg_state
);

  // Handshakes: a write is taken on any wr_en cycle while full is low, otherwise dropped and
  // flagged. Toward the uart, data_en is a one-cycle start pulse with data_in already valid; the
  // uart answers by raising tx_busy and lowering it when done. data_in holds until the next LOAD.

  feeder_state_e         r_state;
  feeder_state_e         w_state_nxt;
  logic                  w_pop;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic                  r_overflow;

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign w_drop    = wr_en && full;
  assign data_en   = (r_state == START);
  assign data_in   = r_data_in;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE:      if (!empty && !tx_busy) w_state_nxt = LOAD;
      LOAD: begin
        w_pop       = 1'b1;
        w_state_nxt = START;
      end
      START:     w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_data_in <= '0;
    else if (w_pop) r_data_in <= w_rd_data;
  end

  // A drop in the same cycle as ovf_clr keeps the flag set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

`ifdef UART_TXQ_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: loopback uart model with a scoreboard of expected transmitted bytes.
import uart_pkg::*;

module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic                  clk;
  logic                  rstn;
  logic [DW-1:0]         wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  empty;
  logic [$clog2(DEPTH):0] count;
  logic                  overflow;
  logic                  ovf_clr;
  logic [DW-1:0]         data_in;
  logic                  data_en;
  logic                  tx_busy;
  feeder_state_e         dbg_state;
`ifdef UART_TXQ_DROP_CNT_EN
  logic [7:0]            drop_cnt;
`endif

  uart_tx_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .data_in   (data_in),
    .data_en   (data_en),
    .tx_busy   (tx_busy),
`ifdef UART_TXQ_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / checking ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- uart model ----------------
  logic force_busy = 1'b0;
  logic stuck      = 1'b0;
  int   busy_len   = 4;
  int   busy_cnt   = 0;
  int   pulses     = 0;
  int   prev_pulse = 0;
  bit   have_prev  = 1'b0;
  int   min_gap    = 1000;

  assign tx_busy = force_busy | (busy_cnt > 0);

  always @(negedge clk) begin
    if (!rstn) begin
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      if (data_en) begin
        pulses++;
        if (have_prev && (cyc - prev_pulse) < min_gap) min_gap = cyc - prev_pulse;
        prev_pulse = cyc;
        have_prev  = 1'b1;
        if (exp_q.size() == 0) check("rx_unexpected", 32'(data_in), 32'hFFFF_FFFF);
        else                   check("rx_data", 32'(data_in), 32'(exp_q.pop_front()));
        if (!stuck) busy_cnt = busy_len;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves the bench at the negedge following the write edge.
  task automatic put_byte(input logic [DW-1:0] b, input bit keep);
    wr_en   = 1'b1;
    wr_data = b;
    if (keep) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || dbg_state != IDLE || tx_busy || !empty) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(n < max_cyc), 32'd1);
  endtask

  task automatic wait_state(input feeder_state_e s, input int max_cyc, input string tag);
    int n = 0;
    while (dbg_state != s && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int max_cnt;
    int sent;
    int n;
    int rx_before;

    rstn = 1'b0; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_data_en", 32'(data_en), 32'd0);
    check("rst_data_in", 32'(data_in), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef UART_TXQ_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // single byte, latency N+2
    busy_len = 40;
    put_byte(8'h5A, 1'b1);
    check("single_n0_data_en", 32'(data_en), 32'd0);
    check("single_n0_count", 32'(count), 32'd1);
    @(negedge clk);
    check("single_n1_state", 32'(dbg_state), 32'(LOAD));
    check("single_n1_data_en", 32'(data_en), 32'd0);
    @(negedge clk);
    check("single_n2_data_en", 32'(data_en), 32'd1);
    check("single_n2_data_in", 32'(data_in), 32'h5A);
    check("single_n2_empty", 32'(empty), 32'd1);
    @(negedge clk);
    check("single_pulse_width", 32'(data_en), 32'd0);
    check("single_data_hold", 32'(data_in), 32'h5A);
    drain(200);

    // burst of 16 while uart held busy, then drain with 4-cycle busy
    busy_len   = 4;
    force_busy = 1'b1;
    for (int i = 1; i <= 16; i++) put_byte(DW'(i), 1'b1);
    check("burst_full", 32'(full), 32'd1);
    check("burst_count", 32'(count), 32'd16);
    min_gap    = 1000;
    force_busy = 1'b0;
    drain(500);
    check("burst_min_gap", 32'(min_gap), 32'(busy_len + 3));

    // overflow and ovf_clr
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) put_byte(DW'($urandom_range(0, 254)), 1'b1);
    put_byte(8'hFF, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
`ifdef UART_TXQ_DROP_CNT_EN
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
`ifdef UART_TXQ_DROP_CNT_EN
    check("ovf_drop_cnt_clr", 32'(drop_cnt), 32'd0);
`endif
    ovf_clr = 1'b1;
    put_byte(8'hEE, 1'b0);
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    check("ovf_count_kept", 32'(count), 32'd16);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    force_busy = 1'b0;
    drain(1000);

    // simultaneous write and LOAD pop
    force_busy = 1'b1;
    put_byte(8'h11, 1'b1);
    put_byte(8'h22, 1'b1);
    force_busy = 1'b0;
    wait_state(LOAD, 20, "simul_reach_load");
    c = int'(count);
    put_byte(8'h33, 1'b1);
    check("simul_count_same", 32'(count), 32'(c));
    drain(200);

    // wrap: 40 bytes streamed with low occupancy
    busy_len = 2;
    max_cnt  = 0;
    sent     = 0;
    n        = 0;
    while (sent < 40 && n < 3000) begin
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (count < 2) begin
        put_byte(DW'($urandom_range(0, 255)), 1'b1);
        sent++;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    check("wrap_sent", 32'(sent), 32'd40);
    check("wrap_max_occupancy", 32'(max_cnt <= 3), 32'd1);
    drain(1000);

    // reset during WAIT_DONE with 5 bytes queued
    busy_len = 40;
    put_byte(8'hA1, 1'b1);
    wait_state(WAIT_DONE, 20, "rst_reach_wait_done");
    for (int i = 0; i < 5; i++) put_byte(DW'(8'hB0 + i), 1'b1);
    check("rst_pre_count", 32'(count), 32'd5);
    rstn = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_data_en", 32'(data_en), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rx_before = pulses;
    repeat (60) @(negedge clk);
    check("postrst_no_pulses", 32'(pulses), 32'(rx_before));
    check("postrst_empty", 32'(empty), 32'd1);

    // stuck uart: busy never rises
    busy_len  = 4;
    stuck     = 1'b1;
    rx_before = pulses;
    put_byte(8'hC3, 1'b1);
    wait_state(WAIT_BUSY, 20, "stuck_reach_wait_busy");
    for (int i = 0; i < 3; i++) put_byte(DW'(8'hD0 + i), 1'b1);
    repeat (30) @(negedge clk);
    check("stuck_state", 32'(dbg_state), 32'(WAIT_BUSY));
    check("stuck_count", 32'(count), 32'd3);
    check("stuck_one_pulse", 32'(pulses), 32'(rx_before + 1));
    stuck      = 1'b0;
    force_busy = 1'b1;
    @(negedge clk);
    force_busy = 1'b0;
    drain(500);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
